// File: rtl/video_io_regs.sv
// ISA-side register front-end for CGA/Tandy/MDA-class video adapters.
// Ports: ISA bus (bus_a/bus_d/strobes/aen) in; crtc_cs, bus_out/bus_dir/bus_rdy out;
// mode/colour registers, palette lookup (pal_rd_*) and update strobe (pal_we/pal_wr_idx),
// cursor/attribute blink, and framebuffer wait-state control via mem_cs/clk_seq.
module video_io_regs #(
    parameter logic [15:0] IO_BASE_ADDR = 16'h3D0,
    parameter int          PAL_ENTRIES  = 16,
    parameter int          PAL_W        = 4,
    parameter logic [23:0] BLINK_MAX    = 24'd2_000_000,
    parameter bit          USE_BUS_WAIT = 1'b0,
    parameter logic [4:0]  WAIT_SLOT    = 5'd17,
    parameter logic [7:0]  WAIT_TIMEOUT = 8'd64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [14:0]      bus_a,
    input  logic [7:0]       bus_d,
    input  logic             bus_aen,
    input  logic             bus_ior_l,
    input  logic             bus_iow_l,
    input  logic             bus_memr_l,
    input  logic             bus_memw_l,
    input  logic             mem_cs,
    input  logic [4:0]       clk_seq,
    input  logic             vsync,
    input  logic             display_enable,
    input  logic             blink_freeze,
    input  logic [3:0]       pal_rd_idx,
    output logic             crtc_cs,
    output logic [7:0]       bus_out,
    output logic             bus_dir,
    output logic             bus_rdy,
    output logic [7:0]       mode_reg,
    output logic [7:0]       color_reg,
    output logic [PAL_W-1:0] pal_rd_data,
    output logic             pal_we,
    output logic [3:0]       pal_wr_idx,
    output logic             blink_fast,
    output logic             blink_slow
);

    localparam logic [4:0] PAL_N = 5'(PAL_ENTRIES);
    localparam logic [7:0] TO_LAST = WAIT_TIMEOUT - 8'd1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE
    } state_t;

    // Address decode on the live bus; aen marks DMA cycles that must not hit I/O.
    logic [15:0] offs;
    logic [3:0]  off;
    logic        in_win;

    assign offs   = {1'b0, bus_a} - IO_BASE_ADDR;
    assign off    = offs[3:0];
    assign in_win = (offs[15:4] == 12'd0) && !bus_aen;
    assign crtc_cs = in_win && !off[3];

    // IOW is asynchronous to the video clock: two-flop synchroniser plus
    // one history flop so a long strobe yields a single write cycle.
    logic iow_s1, iow_s2, iow_s3;
    logic wr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            iow_s1 <= 1'b1;
            iow_s2 <= 1'b1;
            iow_s3 <= 1'b1;
        end else begin
            iow_s1 <= bus_iow_l;
            iow_s2 <= iow_s1;
            iow_s3 <= iow_s2;
        end
    end

    assign wr = iow_s3 && !iow_s2;

    // Register file
    logic [7:0]       index_reg;
    logic [PAL_W-1:0] pal [PAL_ENTRIES];
    logic             pal_hit;

    assign pal_hit = wr && in_win && (off == 4'hE)
                     && (index_reg[7:4] == 4'h1)
                     && ({1'b0, index_reg[3:0]} < PAL_N);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_reg   <= 8'h29;
            color_reg  <= 8'h00;
            index_reg  <= 8'h00;
            pal_we     <= 1'b0;
            pal_wr_idx <= 4'h0;
            for (int i = 0; i < PAL_ENTRIES; i++) begin
                pal[i] <= PAL_W'(i);
            end
        end else begin
            pal_we <= pal_hit;
            if (pal_hit) begin
                pal_wr_idx <= index_reg[3:0];
            end
            if (wr && in_win) begin
                if (off == 4'h8) mode_reg  <= bus_d;
                if (off == 4'h9) color_reg <= bus_d;
                if (off == 4'hA) index_reg <= bus_d;
            end
            for (int i = 0; i < PAL_ENTRIES; i++) begin
                if (pal_hit && (index_reg[3:0] == 4'(i))) begin
                    pal[i] <= bus_d[PAL_W-1:0];
                end
            end
        end
    end

    // Out-of-range lookups return zero rather than aliasing.
    always_comb begin
        pal_rd_data = '0;
        for (int i = 0; i < PAL_ENTRIES; i++) begin
            if (pal_rd_idx == 4'(i)) begin
                pal_rd_data = pal[i];
            end
        end
    end

    // Status read path
    logic vsync_q, de_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vsync_q <= 1'b0;
            de_q    <= 1'b0;
        end else begin
            vsync_q <= vsync;
            de_q    <= display_enable;
        end
    end

    // CRTC reads only claim the bus; data is muxed in above this block.
    always_comb begin
        bus_out = 8'h00;
        bus_dir = 1'b0;
        if (in_win && !bus_ior_l) begin
            if (off == 4'hA) begin
                bus_out = {4'hF, vsync_q, 2'b10, ~de_q};
                bus_dir = 1'b1;
            end else if (crtc_cs) begin
                bus_dir = 1'b1;
            end
        end
    end

    // Blink generator; slow blink advances on each fast 0->1 transition.
    logic [23:0] blink_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_cnt  <= 24'd0;
            blink_fast <= 1'b0;
            blink_slow <= 1'b0;
        end else if (!blink_freeze) begin
            if (blink_cnt == BLINK_MAX) begin
                blink_cnt  <= 24'd0;
                blink_fast <= ~blink_fast;
                if (!blink_fast) begin
                    blink_slow <= ~blink_slow;
                end
            end else begin
                blink_cnt <= blink_cnt + 24'd1;
            end
        end
    end

    // Framebuffer wait-state FSM
    state_t     state, state_nxt;
    logic [7:0] wcnt, wcnt_nxt;
    logic       acc;

    assign acc = USE_BUS_WAIT && mem_cs && (!bus_memr_l || !bus_memw_l);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            wcnt  <= 8'd0;
        end else begin
            state <= state_nxt;
            wcnt  <= wcnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        bus_rdy   = 1'b1;
        case (state)
            ST_IDLE: begin
                if (acc) begin
                    state_nxt = ST_WAIT;
                    wcnt_nxt  = 8'd0;
                end
            end
            ST_WAIT: begin
                bus_rdy = 1'b0;
                if (!acc) begin
                    state_nxt = ST_IDLE;
                end else if (clk_seq == WAIT_SLOT || wcnt == TO_LAST) begin
                    state_nxt = ST_DONE;
                end else begin
                    wcnt_nxt = wcnt + 8'd1;
                end
            end
            ST_DONE: begin
                if (!acc) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule
